// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave: FSM state encoding,
// default RAM depth and the 2-bit command field values.
package spi_pkg;

    localparam int DEF_MEM_DEPTH = 256;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_sva.sv
// Protocol assertions and covers for spi_slave; compiled only when
// SPI_SLAVE_SVA_EN is defined.
`ifdef SPI_SLAVE_SVA_EN
module spi_slave_sva
    import spi_pkg::*;
#(
    parameter int WORD_W = 10
) (
    input logic              clk,
    input logic              rst,
    input logic              SS_n,
    input logic              MISO,
    input logic              rx_valid,
    input logic [WORD_W-1:0] rx_data,
    input logic              ser_busy,
    input state_e            state
);
    a_rx_valid_single: assert property (@(posedge clk) disable iff (rst)
        rx_valid |=> !rx_valid);
    a_miso_window: assert property (@(posedge clk) disable iff (rst)
        MISO |-> ser_busy);
    a_ss_idle: assert property (@(posedge clk) disable iff (rst)
        SS_n |=> state == IDLE);
    a_reset_outputs: assert property (@(posedge clk)
        rst |=> (!MISO && !rx_valid && rx_data == {WORD_W{1'b0}}));

    c_rx_valid: cover property (@(posedge clk) rx_valid);
    c_miso_burst: cover property (@(posedge clk) ser_busy);
endmodule
`endif

// File: rtl/spi_tx_serializer.sv
// Parallel-in/serial-out shifter driving MISO, MSB first, one bit per cycle.
// MISO is registered and forced to 0 whenever no burst is in flight.
module spi_tx_serializer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         abort,
    input  logic [W-1:0] data,
    output logic         miso,
    output logic         busy,
    output logic         done
);
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    logic [W-1:0]     sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             miso_q, miso_d;
    logic             done_q, done_d;

    // Next-state: load presents the MSB right away; cnt_q counts bits still to go.
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        miso_d = 1'b0;
        done_d = 1'b0;
        if (abort) begin
            busy_d = 1'b0;
            cnt_d  = {CNT_W{1'b0}};
        end else if (load) begin
            miso_d = data[W-1];
            sh_d   = {data[W-2:0], 1'b0};
            cnt_d  = CNT_LAST;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == {CNT_W{1'b0}}) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                miso_d = sh_q[W-1];
                sh_d   = {sh_q[W-2:0], 1'b0};
                cnt_d  = cnt_q - CNT_W'(1);
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q   <= {W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            busy_q <= 1'b0;
            miso_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            miso_q <= miso_d;
            done_q <= done_d;
        end
    end

    assign miso = miso_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for a single-port RAM: deserializes command+payload
// words from MOSI and returns read data on MISO. Optional SPI_SLAVE_SVA_EN adds assertions.
module spi_slave
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);
    localparam int WORD_W = ADDR_SIZE + 2;
    localparam int CNT_W  = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [WORD_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rd_addr_seen_q, rd_addr_seen_d;
    logic                word_done_q, word_done_d;
    logic                tx_loaded_q, tx_loaded_d;
    logic                armed_q, armed_d;
    logic                ser_load_s, ser_busy_s, ser_done_s;

    // Frame FSM next-state; SS_n high aborts everything except rd_addr_seen.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        word_done_d    = word_done_q;
        tx_loaded_d    = tx_loaded_q;
        armed_d        = armed_q;
        ser_load_s     = 1'b0;
        rd_addr_seen_d = ser_done_s ? 1'b0 : rd_addr_seen_q;
        if (SS_n) begin
            state_d     = IDLE;
            bit_cnt_d   = {CNT_W{1'b0}};
            word_done_d = 1'b0;
            tx_loaded_d = 1'b0;
            armed_d     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // armed_q keeps a frame cut by reset from resuming without SS_n going high
                    if (armed_q) state_d = CHK_CMD;
                    else         state_d = IDLE;
                end
                CHK_CMD: begin
                    if (!MOSI)               state_d = WRITE;
                    else if (rd_addr_seen_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!word_done_q) begin
                        shift_d = {shift_q[WORD_W-2:0], MOSI};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d   = {CNT_W{1'b0}};
                            word_done_d = 1'b1;
                            rx_data_d   = {shift_q[WORD_W-2:0], MOSI};
                            rx_valid_d  = 1'b1;
                            if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
                            else                     rd_addr_seen_d = rd_addr_seen_q;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (state_q == READ_DATA && !tx_loaded_q && !ser_busy_s && tx_valid) begin
                        ser_load_s  = 1'b1;
                        tx_loaded_d = 1'b1;
                    end else begin
                        tx_loaded_d = tx_loaded_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Single register block for the FSM and its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= {CNT_W{1'b0}};
            shift_q        <= {WORD_W{1'b0}};
            rx_data_q      <= {WORD_W{1'b0}};
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            word_done_q    <= 1'b0;
            tx_loaded_q    <= 1'b0;
            armed_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            word_done_q    <= word_done_d;
            tx_loaded_q    <= tx_loaded_d;
            armed_q        <= armed_d;
        end
    end

    spi_tx_serializer #(.W(ADDR_SIZE)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (ser_load_s),
        .abort (SS_n),
        .data  (tx_data),
        .miso  (MISO),
        .busy  (ser_busy_s),
        .done  (ser_done_s)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_SVA_EN
    spi_slave_sva #(.WORD_W(WORD_W)) u_sva (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MISO     (MISO),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .ser_busy (ser_busy_s),
        .state    (state_q)
    );
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: table of write/read-address frames,
// scoreboarded rx words and MISO bits, plus abort/reset/read corner sequences.
module tb_spi_slave;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst, SS_n, MOSI, tx_valid, MISO, rx_valid;
    logic [7:0] tx_data;
    logic [9:0] rx_data;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic mon_en   = 1'b0;
    logic prev_rx_valid = 1'b0;
    logic [9:0] rx_q[$];
    logic       miso_q[$];

    typedef struct {
        logic       cmd;
        logic [9:0] word;
        logic [9:0] exp_rx;
        logic       exp_seen;
        state_e     exp_state;
    } vec_t;
    vec_t vecs[4];

    spi_slave dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (rx_valid) begin
                check("rx_valid_single", {31'd0, prev_rx_valid}, 32'd0);
                if (rx_q.size() == 0) check("rx_unexpected", {31'd0, rx_valid}, 32'd0);
                else check("rx_data_sb", {22'd0, rx_data}, {22'd0, rx_q.pop_front()});
            end
            if (miso_q.size() != 0) check("miso_bit", {31'd0, MISO}, {31'd0, miso_q.pop_front()});
            else if (MISO !== 1'b0) check("miso_idle", {31'd0, MISO}, 32'd0);
        end
        prev_rx_valid = rx_valid;
    end

    task automatic send_frame(input logic cmd, input logic [9:0] w, input int nbits);
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
        @(negedge clk); MOSI = cmd;
        for (int i = 9; i >= 10 - nbits; i--) begin
            @(negedge clk); MOSI = w[i];
        end
        @(negedge clk); MOSI = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk); SS_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd_word;
        rd_word = 8'hC3;
        vecs[0] = '{1'b0, 10'h0A5, 10'h0A5, 1'b0, WRITE};
        vecs[1] = '{1'b0, 10'h13C, 10'h13C, 1'b0, WRITE};
        vecs[2] = '{1'b0, 10'h3FF, 10'h3FF, 1'b0, WRITE};
        vecs[3] = '{1'b1, 10'h2A5, 10'h2A5, 1'b1, READ_ADD};

        // Reset overrides an active SS_n with MOSI high
        rst = 1'b1; SS_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_rx_data", {22'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_state", dut.state_q, IDLE);
        check("rst_seen", {31'd0, dut.rd_addr_seen_q}, 32'd0);
        rst = 1'b0; SS_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        for (int v = 0; v < 4; v++) begin
            rx_q.push_back(vecs[v].exp_rx);
            send_frame(vecs[v].cmd, vecs[v].word, 10);
            check("vec_rx_data", {22'd0, rx_data}, {22'd0, vecs[v].exp_rx});
            check("vec_state", dut.state_q, vecs[v].exp_state);
            check("vec_seen", {31'd0, dut.rd_addr_seen_q}, {31'd0, vecs[v].exp_seen});
            end_frame();
            check("vec_idle", dut.state_q, IDLE);
        end

        // Read data burst: C3 shifted out MSB first
        rx_q.push_back(10'h300);
        send_frame(1'b1, 10'h300, 10);
        check("rd_state", dut.state_q, READ_DATA);
        tx_data = rd_word; tx_valid = 1'b1;
        for (int i = 7; i >= 0; i--) miso_q.push_back(rd_word[i]);
        @(negedge clk); tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("rd_seen_cleared", {31'd0, dut.rd_addr_seen_q}, 32'd0);
        check("rd_hold_state", dut.state_q, READ_DATA);
        end_frame();

        // Read without tx_valid: MISO stays low, FSM holds until SS_n high
        rx_q.push_back(10'h2A5);
        send_frame(1'b1, 10'h2A5, 10);
        end_frame();
        rx_q.push_back(10'h300);
        send_frame(1'b1, 10'h300, 10);
        repeat (15) @(negedge clk);
        check("notx_state", dut.state_q, READ_DATA);
        check("notx_miso", {31'd0, MISO}, 32'd0);
        end_frame();
        check("notx_idle", dut.state_q, IDLE);
        check("notx_seen_kept", {31'd0, dut.rd_addr_seen_q}, 32'd1);

        // Abort after 5 of 10 bits
        send_frame(1'b0, 10'h155, 5);
        SS_n = 1'b1;
        @(negedge clk);
        check("abort_idle", dut.state_q, IDLE);
        check("abort_rx_hold", {22'd0, rx_data}, 32'h300);
        check("abort_cnt", {28'd0, dut.bit_cnt_q}, 32'd0);
        rx_q.push_back(10'h155);
        send_frame(1'b0, 10'h155, 10);
        check("after_abort_rx", {22'd0, rx_data}, 32'h155);
        end_frame();

        // Abort mid-burst after 3 MISO bits; rd_addr_seen must survive
        rx_q.push_back(10'h300);
        send_frame(1'b1, 10'h300, 10);
        tx_data = rd_word; tx_valid = 1'b1;
        for (int i = 7; i >= 5; i--) miso_q.push_back(rd_word[i]);
        @(negedge clk); tx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); SS_n = 1'b1;
        @(negedge clk);
        check("burst_abort_idle", dut.state_q, IDLE);
        check("burst_abort_seen", {31'd0, dut.rd_addr_seen_q}, 32'd1);
        check("burst_abort_miso", {31'd0, MISO}, 32'd0);

        // Reset mid-frame discards the partial word
        send_frame(1'b0, 10'h0F0, 4);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_state", dut.state_q, IDLE);
        check("mid_rst_rx", {22'd0, rx_data}, 32'd0);
        check("mid_rst_seen", {31'd0, dut.rd_addr_seen_q}, 32'd0);
        rst = 1'b0; SS_n = 1'b1;
        @(negedge clk);
        rx_q.push_back(10'h0A5);
        send_frame(1'b0, 10'h0A5, 10);
        check("post_rst_rx", {22'd0, rx_data}, 32'h0A5);
        end_frame();

        repeat (2) @(negedge clk);
        check("rx_pending", rx_q.size(), 32'd0);
        check("miso_pending", miso_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
